spm_seq_ctrl: RTL and testbench

//  Sequencer for the serial-parallel multiplier (spm) datapath. Accepts one operand pair per

---
 rtl/spm_pkg.sv | 16 +
 rtl/spm_seq_ctrl_deser.sv | 42 ++++
 rtl/spm_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spm_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared types and helpers for the serial-parallel multiplier sequencer.
// The run length covers every product bit plus the spm output pipeline delay.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } spm_state_t;

  function automatic int spm_run_len(input int width, input int p_lat);
    return (2 * width) + p_lat;
  endfunction

endpackage

// File: rtl/spm_seq_ctrl_deser.sv
// Serial-to-parallel product collector: product bits arrive LSB first and enter at the MSB.
// The finished word is committed to a separate register so it stays put while the next run shifts.
module spm_deser #(
  parameter int DW = 64
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_shift_en,
  input  logic          i_bit,
  input  logic          i_commit,
  output logic [DW-1:0] o_word
);

  logic [DW-1:0] r_shift;
  logic [DW-1:0] r_word;
  logic [DW-1:0] w_shift_nxt;

  // The last shift and the commit share one edge, so the commit takes the post-shift value.
  always_comb begin
    w_shift_nxt = r_shift;
    if (i_shift_en) begin
      w_shift_nxt = {i_bit, r_shift[DW-1:1]};
    end else begin
      w_shift_nxt = r_shift;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_word  <= '0;
    end else begin
      r_shift <= w_shift_nxt;
      if (i_commit) begin
        r_word <= w_shift_nxt;
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/spm_seq_ctrl.sv
// Sequencer for one spm instance: accepts an operand pair, streams the multiplier LSB first,
// collects the serial product and hands the 2*WIDTH-bit result back over valid/ready.
module spm_seq_ctrl
  import spm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1,
  parameter int P_LAT  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH-1:0]     i_in_x,
  input  logic [WIDTH-1:0]     i_in_y,
  output logic [WIDTH-1:0]     o_spm_x,
  output logic                 o_spm_ys,
  output logic                 o_spm_clr,
  input  logic                 i_spm_p,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [2*WIDTH-1:0]   o_out_prod
);

  localparam int             RUN_LEN = spm_run_len(WIDTH, P_LAT);
  localparam int             CW      = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0]  C_LAST  = CW'(RUN_LEN - 1);
  localparam logic [CW-1:0]  C_PLAT  = CW'(P_LAT);
  localparam logic [CW-1:0]  C_ONE   = CW'(1);

  spm_state_t        r_state;
  spm_state_t        w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic              r_ys;
  logic              r_clr;
  logic              r_in_ready;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_run_last;
  logic              w_shift_en;
  logic              w_y_fill;
  logic [WIDTH-1:0]  w_y_shift;
  logic [2*WIDTH-1:0] w_prod;

  assign w_accept   = i_in_valid && r_in_ready && (r_state == IDLE);
  assign w_run_last = (r_state == RUN) && (r_cnt == C_LAST);
  // Bits before P_LAT are still the pipeline flush of spm, not product bits.
  assign w_shift_en = (r_state == RUN) && (r_cnt >= C_PLAT);
  assign w_y_fill   = (SIGNED != 0) ? r_y[WIDTH-1] : 1'b0;
  assign w_y_shift  = {w_y_fill, r_y[WIDTH-1:1]};

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = CLEAR;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CLEAR: begin
        w_state_nxt = RUN;
      end
      RUN: begin
        if (w_run_last) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register and handshake/clear outputs, registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_clr       <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_clr       <= (w_state_nxt != RUN);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Operand capture, serial multiplier stream and run counter.
  // r_ys leads r_y by one shift so that during RUN step k it carries y[k] (or the fill bit).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_ys  <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ys <= 1'b0;
          if (w_accept) begin
            r_x   <= i_in_x;
            r_y   <= i_in_y;
            r_cnt <= '0;
          end
        end
        CLEAR: begin
          r_ys  <= r_y[0];
          r_y   <= w_y_shift;
          r_cnt <= '0;
        end
        RUN: begin
          if (w_run_last) begin
            r_ys <= 1'b0;
          end else begin
            r_ys  <= r_y[0];
            r_y   <= w_y_shift;
            r_cnt <= r_cnt + C_ONE;
          end
        end
        DONE: begin
          r_ys <= 1'b0;
        end
        default: begin
          r_ys  <= 1'b0;
          r_cnt <= '0;
        end
      endcase
    end
  end

  spm_deser #(
    .DW (2 * WIDTH)
  ) u_deser (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_shift_en (w_shift_en),
    .i_bit      (i_spm_p),
    .i_commit   (w_run_last),
    .o_word     (w_prod)
  );

  assign o_in_ready  = r_in_ready;
  assign o_spm_x     = r_x;
  assign o_spm_ys    = r_ys;
  assign o_spm_clr   = r_clr;
  assign o_out_valid = r_out_valid;
  assign o_out_prod  = w_prod;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Directed bench for spm_seq_ctrl: three WIDTH=8 instances (signed P_LAT=1, unsigned P_LAT=1,
// signed P_LAT=2), each driving a behavioural serial-parallel multiplier on its spm_* ports.
module tb_spm_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [7:0]  in_x      [3];
  logic [7:0]  in_y      [3];
  logic [7:0]  spm_x     [3];
  logic        spm_ys    [3];
  logic        spm_clr   [3];
  logic        spm_p     [3];
  logic        out_valid [3];
  logic        out_ready [3];
  logic [15:0] out_prod  [3];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SG = (g == 1) ? 0 : 1;
    localparam int PL = (g == 2) ? 2 : 1;

    spm_seq_ctrl #(.WIDTH(8), .SIGNED(SG), .P_LAT(PL)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid[g]),
      .o_in_ready  (in_ready[g]),
      .i_in_x      (in_x[g]),
      .i_in_y      (in_y[g]),
      .o_spm_x     (spm_x[g]),
      .o_spm_ys    (spm_ys[g]),
      .o_spm_clr   (spm_clr[g]),
      .i_spm_p     (spm_p[g]),
      .o_out_valid (out_valid[g]),
      .i_out_ready (out_ready[g]),
      .o_out_prod  (out_prod[g])
    );

    // Golden spm: accumulate ys_k * x << k, emit bit k of the running sum through PL registers.
    logic [63:0] m_xext;
    logic [63:0] m_sum;
    logic [63:0] m_sum_nxt;
    logic [1:0]  m_dly;
    int          m_k;

    assign m_xext    = (SG != 0) ? {{56{spm_x[g][7]}}, spm_x[g]} : {56'd0, spm_x[g]};
    assign m_sum_nxt = m_sum + (spm_ys[g] ? (m_xext << m_k) : 64'd0);
    assign spm_p[g]  = m_dly[PL-1];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_sum <= 64'd0;
        m_k   <= 0;
        m_dly <= 2'b00;
      end else if (spm_clr[g]) begin
        m_sum <= 64'd0;
        m_k   <= 0;
        m_dly <= 2'b00;
      end else begin
        m_sum <= m_sum_nxt;
        m_k   <= m_k + 1;
        m_dly <= {m_dly[0], m_sum_nxt[m_k]};
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One full transaction; out_ready is withheld for 'hold' cycles in DONE.
  task automatic run_op(input int g, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp, input int lat, input int hold, input string tag);
    int n;
    @(negedge clk);
    in_x[g] = x; in_y[g] = y; in_valid[g] = 1'b1; out_ready[g] = 1'b0;
    check_eq({tag, "_in_ready"}, 64'(in_ready[g]), 64'd1);
    @(negedge clk);
    in_valid[g] = 1'b0;
    n = 0;
    while (!out_valid[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_latency"}, 64'(n), 64'(lat));
    check_eq({tag, "_prod"}, 64'(out_prod[g]), 64'(exp));
    check_eq({tag, "_done_clr"}, 64'({spm_clr[g], spm_ys[g]}), 64'd2);
    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin
        in_valid[g] = 1'b1; in_x[g] = 8'h55; in_y[g] = 8'h55;
      end else begin
        in_valid[g] = 1'b0;
      end
      @(negedge clk);
      check_eq({tag, "_hold"}, {out_prod[g], 7'd0, out_valid[g], 7'd0, in_ready[g]},
               {exp, 7'd0, 1'b1, 7'd0, 1'b0});
    end
    in_valid[g] = 1'b0;
    out_ready[g] = 1'b1;
    @(negedge clk);
    out_ready[g] = 1'b0;
    check_eq({tag, "_release"}, {out_prod[g], 7'd0, out_valid[g], 7'd0, in_ready[g]},
             {exp, 7'd0, 1'b0, 7'd0, 1'b1});
    if (hold > 0) begin
      repeat (3) @(negedge clk);
      check_eq({tag, "_no_accept"}, {spm_x[g], 7'd0, out_valid[g], 7'd0, in_ready[g]},
               {x, 7'd0, 1'b0, 7'd0, 1'b1});
    end
  endtask

  logic [15:0] mon_exp [4] = '{16'h000F, 16'h0001, 16'hC080, 16'h4000};
  logic [7:0]  ops_x   [4] = '{8'h03, 8'hFF, 8'h7F, 8'h80};
  logic [7:0]  ops_y   [4] = '{8'h05, 8'hFF, 8'h80, 8'h80};
  int          mon_idx = 0;
  int          mon_t   [4];
  logic        mon_en  = 1'b0;

  // Product monitor for the back-to-back stream on the P_LAT=2 instance.
  always @(negedge clk) begin
    if (mon_en && out_valid[2]) begin
      if (mon_idx < 4) begin
        check_eq("t6_prod", 64'(out_prod[2]), 64'(mon_exp[mon_idx]));
        mon_t[mon_idx] = cyc;
        if (mon_idx > 0) check_eq("t6_out_interval", 64'(mon_t[mon_idx] - mon_t[mon_idx-1]), 64'd21);
      end
      mon_idx++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    int n;
    int acc_t [4];
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_x[i] = 8'd0; in_y[i] = 8'd0; out_ready[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_state", {spm_x[i], out_prod[i], 4'd0, in_ready[i], spm_ys[i], spm_clr[i], out_valid[i]},
               {8'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    end
    rst_n = 1'b1;

    run_op(0, 8'd3,  8'd5,  16'h000F, 18, 0, "t1");
    run_op(0, 8'hFF, 8'hFF, 16'h0001, 18, 0, "t2_m1m1");
    run_op(0, 8'h7F, 8'h80, 16'hC080, 18, 0, "t2_127m128");
    run_op(0, 8'h80, 8'h80, 16'h4000, 18, 0, "t2_m128m128");
    run_op(1, 8'hFF, 8'hFF, 16'hFE01, 18, 0, "t3_ffff");
    run_op(1, 8'h00, 8'hA5, 16'h0000, 18, 0, "t3_zero");
    run_op(0, 8'hF9, 8'h06, 16'hFFD6, 18, 5, "t4");

    // Reset while RUN is at step k=6 (y=0x7F, so ys is 1 there).
    @(negedge clk);
    in_x[0] = 8'h7F; in_y[0] = 8'h7F; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("t5_in_run", {7'd0, spm_clr[0], 7'd0, spm_ys[0]}, {7'd0, 1'b0, 7'd0, 1'b1});
    rst_n = 1'b0;
    #1;
    check_eq("t5_reset_vals", {spm_x[0], out_prod[0], 4'd0, in_ready[0], spm_ys[0], spm_clr[0], out_valid[0]},
             {8'd0, 16'd0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid[0]) n++;
    end
    check_eq("t5_no_valid", 64'(n), 64'd0);
    run_op(0, 8'd2, 8'd3, 16'h0006, 18, 0, "t5_next");

    run_op(2, 8'd3, 8'd5, 16'h000F, 19, 0, "t6_single");
    mon_en = 1'b1;
    out_ready[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_x[2] = ops_x[i]; in_y[2] = ops_y[i]; in_valid[2] = 1'b1;
      n = 0;
      while (!in_ready[2] && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_eq("t6_accept_wait", 64'(n < 100), 64'd1);
      acc_t[i] = cyc;
      if (i > 0) check_eq("t6_acc_interval", 64'(acc_t[i] - acc_t[i-1]), 64'd21);
      @(negedge clk);
    end
    in_valid[2] = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("t6_count", 64'(mon_idx), 64'd4);
    mon_en = 1'b0;
    out_ready[2] = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
